// File: rtl/des_block_serializer_if.sv
// Byte-stream handshake between the DES result path and the TX FIFO side.
// The master modport belongs to the serializer; the slave modport is the controller/FIFO side.
interface des_block_serializer_if #(
    parameter int unsigned BLOCK_BYTES = 8,
    parameter int unsigned BYTE_W      = 8
);
    logic                          data_ready;
    logic [BLOCK_BYTES*BYTE_W-1:0] block_in;
    logic                          tx_ready;
    logic                          tx_valid;
    logic [BYTE_W-1:0]             tx_data;
    logic                          empty;
    logic                          busy;

    modport master (
        input  data_ready, block_in, tx_ready,
        output tx_valid, tx_data, empty, busy
    );

    modport slave (
        output data_ready, block_in, tx_ready,
        input  tx_valid, tx_data, empty, busy
    );
endinterface

// File: rtl/des_block_serializer.sv
// Captures a DES result block and drains it MSB-byte first over a valid/ready handshake.
// Optional DES_TX_CHECKSUM_EN appends an XOR checksum byte after the data bytes.
module des_block_serializer #(
    parameter int unsigned BLOCK_BYTES = 8,
    parameter int unsigned BYTE_W      = 8
) (
    input logic                    clk,
    input logic                    n_rst,
    des_block_serializer_if.master bus
);
    localparam int unsigned BLOCK_W = BLOCK_BYTES * BYTE_W;
    localparam int unsigned CNT_W   = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

`ifdef DES_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CKSUM = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t               state_q, state_n;
    logic                 dr_prev_q;
    logic [BLOCK_W-1:0]   shift_q, shift_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 tx_valid_q, tx_valid_n;
    logic [BYTE_W-1:0]    tx_data_q, tx_data_n;
    logic                 empty_q, empty_n;
    logic                 busy_q, busy_n;
    logic                 trigger;
    logic                 xfer;
`ifdef DES_TX_CHECKSUM_EN
    logic [BYTE_W-1:0]    cksum_q, cksum_n;
`endif

    assign trigger = bus.data_ready & ~dr_prev_q;
    assign xfer    = tx_valid_q & bus.tx_ready;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            dr_prev_q  <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            empty_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DES_TX_CHECKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            state_q    <= state_n;
            dr_prev_q  <= bus.data_ready;
            shift_q    <= shift_n;
            cnt_q      <= cnt_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
            empty_q    <= empty_n;
            busy_q     <= busy_n;
`ifdef DES_TX_CHECKSUM_EN
            cksum_q    <= cksum_n;
`endif
        end
    end

    // Every output is the registered image of the next-state values computed here.
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        cnt_n      = cnt_q;
        tx_valid_n = tx_valid_q;
        tx_data_n  = tx_data_q;
        empty_n    = 1'b0;
        busy_n     = busy_q;
`ifdef DES_TX_CHECKSUM_EN
        cksum_n    = cksum_q;
`endif

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    shift_n    = bus.block_in;
                    cnt_n      = '0;
                    tx_valid_n = 1'b1;
                    tx_data_n  = bus.block_in[BLOCK_W-1 -: BYTE_W];
                    busy_n     = 1'b1;
`ifdef DES_TX_CHECKSUM_EN
                    cksum_n    = '0;
`endif
                    state_n    = SEND;
                end
            end

            SEND: begin
                if (xfer) begin
`ifdef DES_TX_CHECKSUM_EN
                    cksum_n = cksum_q ^ tx_data_q;
`endif
                    if (cnt_q == LAST_CNT) begin
`ifdef DES_TX_CHECKSUM_EN
                        tx_data_n = cksum_q ^ tx_data_q;
                        state_n   = CKSUM;
`else
                        tx_valid_n = 1'b0;
                        busy_n     = 1'b0;
                        empty_n    = 1'b1;
                        state_n    = DONE;
`endif
                    end else begin
                        // Next byte comes from the pre-shift register so it shows without a bubble.
                        shift_n   = shift_q << BYTE_W;
                        tx_data_n = shift_q[BLOCK_W-BYTE_W-1 -: BYTE_W];
                        cnt_n     = cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef DES_TX_CHECKSUM_EN
            CKSUM: begin
                if (xfer) begin
                    tx_valid_n = 1'b0;
                    busy_n     = 1'b0;
                    empty_n    = 1'b1;
                    state_n    = DONE;
                end
            end
`endif

            DONE: begin
                tx_valid_n = 1'b0;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end

            default: begin
                tx_valid_n = 1'b0;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.empty    = empty_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_des_block_serializer.sv
// Scoreboard bench for des_block_serializer: stimulus pushes expected bytes, a negedge monitor pops them.
module tb_des_block_serializer;
    localparam int unsigned NB = 8
`ifdef DES_TX_CHECKSUM_EN
        + 1
`endif
        ;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    des_block_serializer_if #(.BLOCK_BYTES(8), .BYTE_W(8)) bus ();

    des_block_serializer #(.BLOCK_BYTES(8), .BYTE_W(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.master)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    int         xfer_cnt = 0;
    int         empty_cnt = 0;
    logic       prev_stall = 1'b0;
    logic       prev_empty = 1'b0;
    logic [7:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (prev_stall && bus.tx_valid) chk("stall_hold", 64'(bus.tx_data), 64'(held));
            if (bus.tx_valid && bus.tx_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected no transfer", bus.tx_data);
                end else begin
                    chk("byte", 64'(bus.tx_data), 64'(sb.pop_front()));
                end
            end
            if (bus.empty) begin
                empty_cnt++;
                chk("empty_drained", 64'(sb.size()), 64'd0);
                chk("empty_busy", 64'(bus.busy), 64'd0);
                chk("empty_one_cycle", 64'(prev_empty), 64'd0);
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            held       = bus.tx_data;
            prev_empty = bus.empty;
        end else begin
            prev_stall = 1'b0;
            prev_empty = 1'b0;
        end
    end

    task automatic push_block(input logic [63:0] blk);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < 8; k++) begin
            sb.push_back(blk[63-8*k -: 8]);
            x ^= blk[63-8*k -: 8];
        end
`ifdef DES_TX_CHECKSUM_EN
        sb.push_back(x);
`endif
    endtask

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic run_block(input logic [63:0] blk, input bit stall);
        int lat;
        int base_x;
        int base_e;
        lat    = 0;
        base_x = xfer_cnt;
        base_e = empty_cnt;
        push_block(blk);
        bus.block_in   = blk;
        bus.tx_ready   = 1'b1;
        bus.data_ready = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                chk("first_valid", 64'(bus.tx_valid), 64'd1);
                chk("first_busy", 64'(bus.busy), 64'd1);
            end
            if (bus.empty) begin
                lat = n;
                break;
            end
            bus.tx_ready = stall ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL empty_timeout: got no empty pulse, expected one within 200 cycles");
        end else if (!stall) begin
            chk("latency", 64'(lat), 64'(NB + 1));
        end
        chk("done_busy", 64'(bus.busy), 64'd0);
        bus.tx_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("no_reload", 64'(bus.tx_valid), 64'd0);
        end
        bus.data_ready = 1'b0;
        @(posedge clk); #1;
        chk("xfer_count", 64'(xfer_cnt - base_x), 64'(NB));
        chk("empty_pulses", 64'(empty_cnt - base_e), 64'd1);
    endtask

    initial begin
        int base_x;
        int base_e;
        bus.data_ready = 1'b1;
        bus.block_in   = 64'hDEADBEEFCAFEF00D;
        bus.tx_ready   = 1'b1;
        n_rst          = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
        bus.data_ready = 1'b0;
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_tx_valid", 64'(bus.tx_valid), 64'd0);

        run_block(64'h0123456789ABCDEF, 1'b0);
        run_block(64'h0123456789ABCDEF, 1'b1);

        // Reset after three transfers: the rest of the block is discarded.
        base_x = xfer_cnt;
        base_e = empty_cnt;
        push_block(64'hA1B2C3D4E5F60718);
        bus.block_in   = 64'hA1B2C3D4E5F60718;
        bus.tx_ready   = 1'b1;
        bus.data_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (xfer_cnt - base_x >= 3) break;
        end
        chk("pre_reset_xfers", 64'(xfer_cnt - base_x), 64'd3);
        bus.tx_ready   = 1'b0;
        bus.data_ready = 1'b0;
        n_rst          = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_empty", 64'(bus.empty), 64'd0);
        chk("mid_rst_tx_data", 64'(bus.tx_data), 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_no_empty", 64'(empty_cnt - base_e), 64'd0);

        run_block(64'h0123456789ABCDEF, 1'b0);
        run_block(64'h0102040810204080, 1'b0);
        run_block(64'hFF00FF00FF00FF00, 1'b1);

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
